// File: rtl/ext_int_ctrl.sv
// External interrupt controller: synchronises and edge-detects interrupt lines, latches
// them as pending, and runs an IntReq/IntAck handshake with the CPU for the winning source.
module ext_int_ctrl #(
  parameter  int NUM_SRC = 8,
  localparam int NUM_W   = $clog2(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] int_src_i,
  input  logic               io_sel_i,
  input  logic [3:0]         io_addr_i,
  input  logic               io_wr_i,
  input  logic               io_rd_i,
  input  logic [31:0]        io_wr_data_i,
  output logic [31:0]        io_rd_data_o,
  output logic               int_req_o,
  input  logic               int_ack_i
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q, edge_q;
  logic [NUM_SRC-1:0] ier_q, ier_d, ipr_q, ipr_d;
  logic [NUM_W-1:0]   inr_q, inr_d;
  logic [1:0]         state_q, state_d;
  logic               req_q, req_d;
  logic [31:0]        rd_q, rd_d;

  logic [NUM_SRC-1:0] pend, ack_clr, w1c_clr;
  logic [NUM_W-1:0]   win;
  logic               wr_ier, wr_inr, wr_ipr;
  logic               unused_wr;

  assign unused_wr = ^io_wr_data_i[31:NUM_SRC];

  assign wr_ier = io_sel_i & io_wr_i & (io_addr_i == 4'h0);
  assign wr_inr = io_sel_i & io_wr_i & (io_addr_i == 4'h1);
  assign wr_ipr = io_sel_i & io_wr_i & (io_addr_i == 4'h2);

  // Arbitration always looks at registered state, never at same-cycle writes.
  assign pend = ipr_q & ier_q;

  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (pend[i]) win = NUM_W'(i);
  end

  always_comb begin
    state_d = state_q;
    inr_d   = inr_q;
    req_d   = req_q;
    ack_clr = '0;
    case (state_q)
      IDLE: if (|pend) begin
        inr_d   = win;
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: if (int_ack_i) begin
        ack_clr = NUM_SRC'(1) << inr_q;
        req_d   = 1'b0;
        state_d = SERVICE;
      end else if (!ier_q[inr_q] || !ipr_q[inr_q]) begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
      SERVICE: if (wr_inr) state_d = IDLE;
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // A new edge overrides any clear landing in the same cycle.
  assign w1c_clr = wr_ipr ? io_wr_data_i[NUM_SRC-1:0] : '0;
  assign ipr_d   = (ipr_q & ~(ack_clr | w1c_clr)) | edge_q;
  assign ier_d   = wr_ier ? io_wr_data_i[NUM_SRC-1:0] : ier_q;

  always_comb begin
    rd_d = rd_q;
    if (io_sel_i && io_rd_i) begin
      rd_d = '0;
      case (io_addr_i)
        4'h0: rd_d[NUM_SRC-1:0] = ier_q;
        4'h1: begin
          rd_d[31]        = (state_q != IDLE);
          rd_d[NUM_W-1:0] = inr_q;
        end
        4'h2: rd_d[NUM_SRC-1:0] = ipr_q;
        default: rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
      ier_q   <= '0;
      ipr_q   <= '0;
      inr_q   <= '0;
      state_q <= IDLE;
      req_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      sync1_q <= int_src_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
      ier_q   <= ier_d;
      ipr_q   <= ipr_d;
      inr_q   <= inr_d;
      state_q <= state_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
    end
  end

  assign io_rd_data_o = rd_q;
  assign int_req_o    = req_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl: handshake, priority, masking, races, protocol errors, reset.
module tb_ext_int_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_src;
  logic        io_sel, io_wr, io_rd, int_ack;
  logic [3:0]  io_addr;
  logic [31:0] io_wr_data, io_rd_data;
  logic        int_req;
  int          total = 0;
  int          bad = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  ext_int_ctrl #(.NUM_SRC(8)) dut (
    .clk_i(clk), .rst_i(rst), .int_src_i(int_src), .io_sel_i(io_sel),
    .io_addr_i(io_addr), .io_wr_i(io_wr), .io_rd_i(io_rd),
    .io_wr_data_i(io_wr_data), .io_rd_data_o(io_rd_data),
    .int_req_o(int_req), .int_ack_i(int_ack)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic io_write(input logic [3:0] a, input logic [31:0] d);
    io_sel = 1'b1; io_wr = 1'b1; io_addr = a; io_wr_data = d;
    tick();
    io_sel = 1'b0; io_wr = 1'b0; io_wr_data = '0;
  endtask

  task automatic io_read(input logic [3:0] a, output logic [31:0] d);
    io_sel = 1'b1; io_rd = 1'b1; io_addr = a;
    tick();
    io_sel = 1'b0; io_rd = 1'b0;
    d = io_rd_data;
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; int_src = '0; io_sel = 0; io_wr = 0; io_rd = 0; int_ack = 0;
    io_addr = '0; io_wr_data = '0;
    tick(2);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", int_req); end
    total++; if (io_rd_data !== 32'h0) begin bad++; $display("FAIL rst_rd got=%h exp=0", io_rd_data); end
    rst = 1'b0;
    io_read(4'h0, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst_ier got=%h exp=0", rv); end
    io_read(4'h2, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst_ipr got=%h exp=0", rv); end
    io_read(4'h1, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst_inr got=%h exp=0", rv); end
  endtask

  task automatic test_basic();
    io_write(4'h0, 32'h1);
    int_src = 8'h01;
    tick(3);
    io_read(4'h2, rv);  // samples the cycle before the pending bit lands
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL basic_ipr_early got=%h exp=0", rv); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL basic_req_early got=%b exp=0", int_req); end
    io_read(4'h2, rv);
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL basic_ipr got=%h exp=1", rv); end
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL basic_req got=%b exp=1", int_req); end
    int_src = 8'h00;
    io_read(4'h1, rv);
    total++; if (rv !== 32'h8000_0000) begin bad++; $display("FAIL basic_inr got=%h exp=80000000", rv); end
    ack_pulse();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL basic_ack_req got=%b exp=0", int_req); end
    io_read(4'h2, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL basic_ack_ipr got=%h exp=0", rv); end
    io_read(4'h1, rv);
    total++; if (rv !== 32'h8000_0000) begin bad++; $display("FAIL basic_svc_inr got=%h exp=80000000", rv); end
    io_write(4'h1, 32'h0);
    io_read(4'h1, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL basic_eoi_inr got=%h exp=0", rv); end
  endtask

  task automatic test_priority();
    io_write(4'h0, 32'hFF);
    int_src = 8'h24;
    tick(4);
    int_src = 8'h00;
    tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL prio_req1 got=%b exp=1", int_req); end
    io_read(4'h1, rv);
    total++; if (rv !== 32'h8000_0002) begin bad++; $display("FAIL prio_inr1 got=%h exp=80000002", rv); end
    ack_pulse();
    io_read(4'h2, rv);
    total++; if (rv !== 32'h20) begin bad++; $display("FAIL prio_ipr_mid got=%h exp=20", rv); end
    io_write(4'h1, 32'h0);
    tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL prio_req2 got=%b exp=1", int_req); end
    io_read(4'h1, rv);
    total++; if (rv !== 32'h8000_0005) begin bad++; $display("FAIL prio_inr2 got=%h exp=80000005", rv); end
    ack_pulse();
    io_write(4'h1, 32'h0);
  endtask

  task automatic test_mask_withdraw();
    io_write(4'h0, 32'h0);
    int_src = 8'h08;
    tick(4);
    int_src = 8'h00;
    tick();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL mask_req got=%b exp=0", int_req); end
    io_read(4'h2, rv);
    total++; if (rv !== 32'h08) begin bad++; $display("FAIL mask_ipr got=%h exp=08", rv); end
    io_write(4'h0, 32'h08);
    tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL unmask_req got=%b exp=1", int_req); end
    io_write(4'h0, 32'h0);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL wd_hold got=%b exp=1", int_req); end
    tick();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL wd_req got=%b exp=0", int_req); end
    io_read(4'h2, rv);
    total++; if (rv !== 32'h08) begin bad++; $display("FAIL wd_ipr got=%h exp=08", rv); end
    io_read(4'h1, rv);
    total++; if (rv !== 32'h3) begin bad++; $display("FAIL wd_inr got=%h exp=3", rv); end
    io_write(4'h2, 32'h08);
    io_read(4'h2, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL w1c_ipr got=%h exp=0", rv); end
  endtask

  task automatic test_simultaneous();
    io_write(4'h0, 32'h10);
    int_src = 8'h10;
    tick(4);
    int_src = 8'h00;
    tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL sim_req got=%b exp=1", int_req); end
    io_read(4'h1, rv);
    total++; if (rv !== 32'h8000_0004) begin bad++; $display("FAIL sim_inr got=%h exp=80000004", rv); end
    tick(2);
    int_src = 8'h10;
    tick(3);
    ack_pulse();  // lands on the same edge as the new pending bit
    int_src = 8'h00;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL sim_ack_req got=%b exp=0", int_req); end
    io_read(4'h2, rv);
    total++; if (rv !== 32'h10) begin bad++; $display("FAIL sim_ack_ipr got=%h exp=10", rv); end
    io_write(4'h1, 32'h0);
    tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL sim_rereq got=%b exp=1", int_req); end
    io_read(4'h1, rv);
    total++; if (rv !== 32'h8000_0004) begin bad++; $display("FAIL sim_reinr got=%h exp=80000004", rv); end
    ack_pulse();
    io_write(4'h1, 32'h0);
    io_write(4'h0, 32'h0);
    tick(3);
    int_src = 8'h10;
    tick(3);
    io_write(4'h2, 32'h10);  // W1C on the same edge as the new pending bit
    int_src = 8'h00;
    io_read(4'h2, rv);
    total++; if (rv !== 32'h10) begin bad++; $display("FAIL sim_w1c_ipr got=%h exp=10", rv); end
    io_write(4'h2, 32'h10);
    io_read(4'h2, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL sim_w1c_clr got=%h exp=0", rv); end
  endtask

  task automatic test_protocol();
    ack_pulse();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL proto_idle_ack got=%b exp=0", int_req); end
    io_read(4'h1, rv);
    total++; if (rv !== 32'h4) begin bad++; $display("FAIL proto_idle_inr got=%h exp=4", rv); end
    io_write(4'h0, 32'h1);
    int_src = 8'h01;
    tick(4);
    int_src = 8'h00;
    tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL proto_req got=%b exp=1", int_req); end
    io_write(4'h1, 32'h0);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL proto_eoi_req got=%b exp=1", int_req); end
    io_read(4'h1, rv);
    total++; if (rv !== 32'h8000_0000) begin bad++; $display("FAIL proto_eoi_inr got=%h exp=80000000", rv); end
    io_read(4'hF, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL proto_offF got=%h exp=0", rv); end
    io_write(4'h0, 32'hFFFF_FFFF);
    io_read(4'h0, rv);
    total++; if (rv !== 32'hFF) begin bad++; $display("FAIL proto_ier_w got=%h exp=ff", rv); end
    io_sel = 1'b1; io_wr = 1'b1; io_rd = 1'b1; io_addr = 4'h0; io_wr_data = 32'h0F;
    tick();
    io_sel = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
    total++; if (io_rd_data !== 32'hFF) begin bad++; $display("FAIL proto_wr_rd got=%h exp=ff", io_rd_data); end
    io_read(4'h0, rv);
    total++; if (rv !== 32'h0F) begin bad++; $display("FAIL proto_wr_rd_new got=%h exp=0f", rv); end
    ack_pulse();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL proto_svc_req got=%b exp=0", int_req); end
  endtask

  task automatic test_reset_mid();
    io_read(4'h0, rv);
    total++; if (rv !== 32'h0F) begin bad++; $display("FAIL rmid_pre got=%h exp=0f", rv); end
    int_src = 8'h02;
    rst = 1'b1;
    tick();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", int_req); end
    total++; if (io_rd_data !== 32'h0) begin bad++; $display("FAIL rmid_rd got=%h exp=0", io_rd_data); end
    rst = 1'b0;
    int_src = 8'h00;
    io_read(4'h0, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL rmid_ier got=%h exp=0", rv); end
    io_read(4'h1, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL rmid_inr got=%h exp=0", rv); end
    tick(4);
    io_read(4'h2, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL rmid_ipr got=%h exp=0", rv); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask_withdraw();
    test_simultaneous();
    test_protocol();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ext_int_ctrl.md
Name: ext_int_ctrl

Overview:
- External Interrupt Controller (EIC) for the Kabeta IO space, at device slot EIC_ADDR = 3'h0.
- Synchronises and edge-detects NUM_SRC asynchronous interrupt lines, latches them as pending, and masks them with IER.
- Selects the highest-priority enabled source and runs an IntReq/IntAck handshake with the CPU core.
- Exposes IER (offset 4'h0), INR (offset 4'h1) and IPR (offset 4'h2) on the IO register bus. A write to INR signals end-of-interrupt (EOI).

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 2..31.
- NUM_W, $clog2(NUM_SRC), width of the source number field (derived; not overridden).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- IntSrc  in  NUM_SRC  asynchronous interrupt lines; a rising edge is an event.
- IoSel  in  1  EIC selected (device decode already done upstream).
- IoAddr  in  4  register offset within the EIC.
- IoWr  in  1  write strobe, one cycle, qualified by IoSel.
- IoRd  in  1  read strobe, one cycle, qualified by IoSel.
- IoWrData  in  32  write data.
- IoRdData  out  32  read data, registered.
- IntReq  out  1  interrupt request to the CPU.
- IntAck  in  1  CPU acceptance of IntReq, one-cycle pulse.

Behaviour:
- Reset: IER, IPR, INR, IoRdData, IntReq and all synchroniser flops go to 0; FSM goes to IDLE.
- Input path, per source: 2-flop synchroniser, then a third flop for edge detection; edge = sync & ~prev.
  - The IPR bit is set on the clock after the edge is detected. IntSrc rising before edge N gives IPR set after edge N+3.
  - An IPR bit is set regardless of IER.
- Pending-bit update priority: new edge > clear (by ack or write-1-to-clear). If both happen in the same cycle, the bit stays 1.
- Priority: lowest index wins among (IPR & IER).
- FSM:
  - IDLE: if (IPR & IER) != 0, latch the winning index into INR, register IntReq=1, and go to REQ. IntReq rises 1 cycle after the condition is seen.
  - REQ: IntReq held at 1.
    - On IntAck: clear IPR[INR], drop IntReq on the next edge, go to SERVICE.
    - Withdrawal, when there is no IntAck: if IER[INR] or IPR[INR] has become 0, drop IntReq and return to IDLE. A re-evaluation happens on the following cycle.
    - IntAck and withdrawal in the same cycle: the ack wins.
  - SERVICE: IntReq = 0 and new requests are held off (no nesting). An IO write to INR (EOI) returns the FSM to IDLE; arbitration resumes on the next cycle.
  - IntAck outside REQ is ignored. An EOI outside SERVICE is ignored.
- The FSM always evaluates registered IER/IPR. A same-cycle IO write takes effect for arbitration on the next cycle.
- Register map (IoSel=1):
  - 0x0 IER: read/write, bits[NUM_SRC-1:0]; upper bits read 0 and ignore writes.
  - 0x1 INR: read returns {bit31 = (state != IDLE), bits[NUM_W-1:0] = INR, others 0}. Any write performs EOI; the data is ignored.
  - 0x2 IPR: read returns pending bits. A write clears the bits written as 1 (write-1-to-clear); a same-cycle edge still wins.
  - Other offsets read 0; writes to them are ignored.
- Read timing: IoRdData is updated on the edge after IoSel & IoRd and holds until the next read. It is 0 after reset.
- IoWr & IoRd asserted together: the write is performed, and the read returns the pre-write value.
- Reset asserted mid-handshake: IntReq drops on the next edge; pending events are lost.

Test Plan:
- Basic request: after reset, write IER=0x01, pulse IntSrc[0] -> IPR=0x01 after 3 cycles, IntReq=1 one cycle later. Read INR -> 0x8000_0000. IntAck -> IntReq=0, IPR=0x00. Write INR -> FSM returns to IDLE.
- Priority: IER=0xFF, raise IntSrc[5] and IntSrc[2] in the same cycle -> INR=2. After ack and EOI, a second request is made with INR=5. IPR reads 0x20 between the two requests.
- Masking and withdrawal: IER=0x00, edge on source 3 -> IPR=0x08 and IntReq stays 0. Write IER=0x08 -> IntReq rises. Write IER=0x00 before IntAck -> IntReq falls and the FSM returns to IDLE with IPR=0x08 retained.
- Simultaneous events: in REQ with INR=4, a new IntSrc[4] edge lands in the same cycle as IntAck -> IPR[4] stays 1. After EOI, a new request is made with INR=4. Separately, a W1C write of IPR=0x10 coinciding with a new edge leaves bit 4 set.
- Protocol errors: IntAck pulse in IDLE, and an INR write in REQ -> no state change. Read offset 0xF -> 0. Write IER=0xFFFF_FFFF with NUM_SRC=8 -> reads back 0x0000_00FF.
- Reset mid-operation: assert Reset while in SERVICE -> all registers 0, IntReq=0, IoRdData=0 on the next edge.
